// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/step/burst/halt sequencer issuing single-cycle clock enables to the CPU
module cpu_step_ctrl #(
    parameter int DIV_W       = 25,
    parameter int DEFAULT_DIV = 2500000,
    parameter int DB_CYCLES   = 500000,
    parameter int BURST_W     = 8
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               halt_req,
    input  logic               div_load,
    input  logic [DIV_W-1:0]   div_value,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_count,
    output logic               cpu_ce,
    output logic               cpu_clk,
    output logic [1:0]         state,
    output logic [15:0]        steps_done
);
    localparam int DB_W = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BURST = 2'b11} state_t;

    state_t             state_q, state_d;
    logic               run_s1_q, run_s1_d, run_s2_q, run_s2_d;
    logic               btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               db_lvl_q, db_lvl_d;
    logic               step_evt_q, step_evt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   rate_cnt_q, rate_cnt_d;
    logic [BURST_W-1:0] burst_rem_q, burst_rem_d;
    logic               cpu_ce_q, cpu_ce_d;
    logic               cpu_clk_q, cpu_clk_d;
    logic [15:0]        steps_q, steps_d;
    logic               db_diff, db_hit, rate_on, tick;

    // Synchronizers, button debounce, rate divider and divisor register
    always_comb begin
        run_s1_d   = run_sw;
        run_s2_d   = run_s1_q;
        btn_s1_d   = step_btn;
        btn_s2_d   = btn_s1_q;
        db_diff    = btn_s2_q != db_lvl_q;
        db_hit     = db_diff && db_cnt_q == DB_W'(DB_CYCLES - 1);
        db_cnt_d   = (db_diff && !db_hit) ? db_cnt_q + DB_W'(1) : '0;
        db_lvl_d   = db_hit ? btn_s2_q : db_lvl_q;
        step_evt_d = db_hit && btn_s2_q;
        rate_on    = state_q == RUN || state_q == BURST;
        tick       = rate_on && rate_cnt_q == div_q - DIV_W'(1);
        rate_cnt_d = (!rate_on || tick) ? '0 : rate_cnt_q + DIV_W'(1);
        div_d      = (div_load && state_q == HALT) ? (div_value == '0 ? DIV_W'(1) : div_value) : div_q;
    end

    // Mode sequencing; the enable pulse is decided here and registered
    always_comb begin
        state_d     = state_q;
        cpu_ce_d    = 1'b0;
        burst_rem_d = burst_rem_q;
        case (state_q)
            HALT: begin
                if (step_evt_q) begin
                    state_d  = STEP;
                    cpu_ce_d = 1'b1;
                end else if (burst_start && burst_count != '0 && !halt_req) begin
                    state_d     = BURST;
                    burst_rem_d = burst_count;
                end else if (run_s2_q && !halt_req) begin
                    state_d = RUN;
                end
            end
            STEP: state_d = HALT;
            RUN: begin
                if (halt_req || !run_s2_q) state_d = HALT;
                else cpu_ce_d = tick;
            end
            BURST: begin
                if (halt_req) begin
                    state_d     = HALT;
                    burst_rem_d = '0;
                end else if (tick) begin
                    cpu_ce_d    = 1'b1;
                    burst_rem_d = burst_rem_q - BURST_W'(1);
                    state_d     = burst_rem_q == BURST_W'(1) ? HALT : BURST;
                end
            end
            default: state_d = HALT;
        endcase
        cpu_clk_d = cpu_clk_q ^ cpu_ce_d;
        steps_d   = steps_q + {15'b0, cpu_ce_d};
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HALT;
            run_s1_q    <= 1'b0;
            run_s2_q    <= 1'b0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            db_cnt_q    <= '0;
            db_lvl_q    <= 1'b0;
            step_evt_q  <= 1'b0;
            div_q       <= DIV_W'(DEFAULT_DIV);
            rate_cnt_q  <= '0;
            burst_rem_q <= '0;
            cpu_ce_q    <= 1'b0;
            cpu_clk_q   <= 1'b0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_d;
            run_s1_q    <= run_s1_d;
            run_s2_q    <= run_s2_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            db_cnt_q    <= db_cnt_d;
            db_lvl_q    <= db_lvl_d;
            step_evt_q  <= step_evt_d;
            div_q       <= div_d;
            rate_cnt_q  <= rate_cnt_d;
            burst_rem_q <= burst_rem_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_clk_q   <= cpu_clk_d;
            steps_q     <= steps_d;
        end
    end

    assign cpu_ce     = cpu_ce_q;
    assign cpu_clk    = cpu_clk_q;
    assign state      = state_q;
    assign steps_done = steps_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench predicting the cycle of every cpu_ce pulse
module tb_cpu_step_ctrl;
    localparam int DIV_W = 8;
    localparam int BURST_W = 4;

    logic               clk_in = 1'b0;
    logic               reset_n = 1'b0;
    logic               run_sw = 1'b0;
    logic               step_btn = 1'b0;
    logic               halt_req = 1'b0;
    logic               div_load = 1'b0;
    logic [DIV_W-1:0]   div_value = '0;
    logic               burst_start = 1'b0;
    logic [BURST_W-1:0] burst_count = '0;
    logic               cpu_ce, cpu_clk;
    logic [1:0]         state;
    logic [15:0]        steps_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_steps = 0;
    int sb[$];

    cpu_step_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(4), .DB_CYCLES(3), .BURST_W(BURST_W)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .run_sw(run_sw), .step_btn(step_btn),
        .halt_req(halt_req), .div_load(div_load), .div_value(div_value),
        .burst_start(burst_start), .burst_count(burst_count), .cpu_ce(cpu_ce),
        .cpu_clk(cpu_clk), .state(state), .steps_done(steps_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void expect_ce(int t);
        sb.push_back(t);
        exp_steps++;
    endfunction

    // every observed pulse must match the next predicted cycle
    always @(negedge clk_in) begin
        if (reset_n && cpu_ce === 1'b1) begin
            if (sb.size() == 0) chk("ce_extra", {31'b0, cpu_ce}, 0);
            else chk("ce_cycle", cyc, sb.pop_front());
        end
    end

    task automatic clk_n(int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_state"}, {30'b0, state}, 0);
        chk({tag, "_steps"}, {16'b0, steps_done}, exp_steps & 32'hFFFF);
        chk({tag, "_clk"}, {31'b0, cpu_clk}, exp_steps & 1);
    endtask

    task automatic load_div(int v);
        div_load = 1'b1;
        div_value = DIV_W'(v);
        clk_n(1);
        div_load = 1'b0;
    endtask

    task automatic do_run(int n, int div, bit mid_load);
        int c = cyc;
        for (int t = c + 3 + div; t <= c + n + 2; t += div) expect_ce(t);
        run_sw = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_in);
            div_load = mid_load && i == 5;
            div_value = 9;
            if (i == 3) chk("run_entry", {30'b0, state}, 1);
        end
        run_sw = 1'b0;
        div_load = 1'b0;
        clk_n(4);
        chk_idle("run_stop");
    endtask

    task automatic press();
        int c = cyc;
        expect_ce(c + 8);
        step_btn = 1'b1;
        clk_n(1);
        step_btn = 1'b0;
        clk_n(1);
        step_btn = 1'b1;
        clk_n(6);
        chk("step_state", {30'b0, state}, 2);
        clk_n(4);
        step_btn = 1'b0;
        clk_n(1);
        step_btn = 1'b1;
        clk_n(1);
        step_btn = 1'b0;
        clk_n(10);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #1;
        chk("rst_ce", {31'b0, cpu_ce}, 0);
        chk_idle("rst");
        clk_n(2);
        reset_n = 1'b1;
        clk_n(1);
        chk_idle("post_rst");
        do_run(14, 4, 1'b0);
        press();
        chk_idle("step");
        load_div(2);
        c = cyc;
        for (int k = 1; k <= 5; k++) expect_ce(c + 1 + 2 * k);
        burst_start = 1'b1;
        burst_count = 5;
        clk_n(1);
        burst_start = 1'b0;
        clk_n(1);
        chk("burst_state", {30'b0, state}, 3);
        clk_n(10);
        chk_idle("burst5");
        c = cyc;
        expect_ce(c + 3);
        expect_ce(c + 5);
        burst_start = 1'b1;
        burst_count = 8;
        clk_n(1);
        burst_start = 1'b0;
        clk_n(5);
        halt_req = 1'b1;
        clk_n(2);
        chk_idle("abort");
        run_sw = 1'b1;
        clk_n(6);
        chk("halt_blocks_run", {30'b0, state}, 0);
        press();
        chk_idle("halt_step");
        run_sw = 1'b0;
        clk_n(4);
        halt_req = 1'b0;
        clk_n(4);
        chk_idle("halt_release");
        do_run(14, 2, 1'b1);
        load_div(0);
        do_run(65535 - exp_steps + 1, 1, 1'b0);
        chk("steps_ffff", {16'b0, steps_done}, 32'hFFFF);
        press();
        chk("steps_wrap", {16'b0, steps_done}, 0);
        load_div(4);
        c = cyc;
        expect_ce(c + 5);
        burst_start = 1'b1;
        burst_count = 8;
        clk_n(1);
        burst_start = 1'b0;
        clk_n(4);
        chk("pre_rst_ce", {31'b0, cpu_ce}, 1);
        #2;
        reset_n = 1'b0;
        exp_steps = 0;
        #1;
        chk("async_rst_ce", {31'b0, cpu_ce}, 0);
        chk_idle("async_rst");
        clk_n(2);
        reset_n = 1'b1;
        clk_n(5);
        chk_idle("after_rst");
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
